// File: rtl/mult_wb_unit.sv
// mult_wb_unit
//   Iterative radix-2 shift-add multiplier that sits beside an 8 x WIDTH
//   register file. It takes the two read-port operands and a destination
//   select, runs WIDTH add/shift steps, then holds the product until the main
//   datapath grants the shared RF write port.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake; a transfer happens on a rising edge
//                       where in_valid & in_ready & ~kill are all 1. in_ready
//                       depends only on state, never on in_valid.
//   op_a, op_b          unsigned multiplicand / multiplier
//   op_hi               0: return low half of product, 1: high half
//   dst_sel             destination register select
//   kill                synchronous abort of an in-flight or held operation
//   wb_grant            RF write port is free this cycle
//   wr_en/wr_sel/wr_data  RF write port contribution (all 0 outside DONE)
//   pend_valid/pend_sel outstanding-write indication for decode stalls
//   dbg_state           current FSM state (0 idle, 1 busy, 2 done)
module mult_wb_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_hi,
  input  logic [2:0]       dst_sel,
  input  logic             kill,
  input  logic             wb_grant,
  output logic             wr_en,
  output logic [2:0]       wr_sel,
  output logic [WIDTH-1:0] wr_data,
  output logic             pend_valid,
  output logic [2:0]       pend_sel,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2:0]         dst_q,    dst_d;
  logic               hi_q,     hi_d;

  logic               in_done;
  logic [WIDTH-1:0]   result;

  assign in_done = (state_q == S_DONE);
  assign result  = hi_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    hi_d     = hi_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !kill) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, op_a};
          mplier_d = op_b;
          cnt_d    = '0;
          dst_d    = dst_sel;
          hi_d     = op_hi;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          // cnt_q counts completed steps; this cycle performs step WIDTH.
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // kill and grant both leave DONE; kill additionally suppresses wr_en.
        if (kill || wb_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
      hi_q     <= hi_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign wr_en      = in_done && wb_grant && !kill;
  assign wr_sel     = in_done ? dst_q : 3'd0;
  assign wr_data    = in_done ? result : '0;
  // The RF bypasses the write to same-cycle readers, so pending can drop as
  // soon as the unit leaves DONE.
  assign pend_valid = (state_q == S_BUSY) || in_done;
  assign pend_sel   = dst_q;
  assign dbg_state  = state_q;

endmodule
